// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: memory command, access size and FSM states.
package mem_lsu_pkg;

   localparam logic MEM_CMD_READ  = 1'b0;
   localparam logic MEM_CMD_WRITE = 1'b1;

   typedef enum logic [1:0] {
      LSU_SIZE_B = 2'd0,
      LSU_SIZE_H = 2'd1,
      LSU_SIZE_W = 2'd2,
      LSU_SIZE_X = 2'd3
   } lsu_size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   function automatic logic [31:0] word_addr(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Byte-lane steering for a 32-bit port: store mask/data placement, load extract/extend, alignment check.
module mem_lsu_lane_align
   import mem_lsu_pkg::*;
(
   input  lsu_size_e   size_i,
   input  logic [1:0]  off_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] load_data_i,
   output logic [3:0]  mask_o,
   output logic [31:0] lane_wdata_o,
   output logic [31:0] ext_load_o,
   output logic        misaligned_o
);

   logic [4:0]  shamt;
   logic [31:0] rd_shifted;

   assign shamt      = {off_i, 3'b000};
   assign rd_shifted = load_data_i >> shamt;

   // size 3 is reported through misaligned_o so the caller has a single error source
   always_comb begin
      mask_o       = 4'h0;
      lane_wdata_o = 32'h0;
      ext_load_o   = 32'h0;
      misaligned_o = 1'b0;
      case (size_i)
         LSU_SIZE_B: begin
            mask_o       = 4'b0001 << off_i;
            lane_wdata_o = {24'h0, wdata_i[7:0]} << shamt;
            ext_load_o   = {{24{rd_shifted[7] & ~unsigned_i}}, rd_shifted[7:0]};
         end
         LSU_SIZE_H: begin
            mask_o       = 4'b0011 << off_i;
            lane_wdata_o = {16'h0, wdata_i[15:0]} << shamt;
            ext_load_o   = {{16{rd_shifted[15] & ~unsigned_i}}, rd_shifted[15:0]};
            misaligned_o = off_i[0];
         end
         LSU_SIZE_W: begin
            mask_o       = 4'hF;
            lane_wdata_o = wdata_i;
            ext_load_o   = load_data_i;
            misaligned_o = (off_i != 2'b00);
         end
         default: misaligned_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: one request at a time, registered memory port, read timeout, extended result.
//
//   state     | meaning
//   ST_IDLE   | req_ready high, waiting for req_valid
//   ST_ACCESS | mem_enable high, port held; one cycle for stores, until valid/timeout for loads
//   ST_RESP   | one-cycle resp_valid pulse
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_cmd_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_data_o,
   output logic        resp_err_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_mask_o,
   output logic        mem_enable_o,
   output logic        mem_cmd_o,
   output logic [31:0] mem_write_data_o,
   input  logic [31:0] mem_load_data_i,
   input  logic        mem_valid_i
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_e    state_q;
   logic          cmd_q;
   lsu_size_e     size_q;
   logic          unsigned_q;
   logic [1:0]    off_q;
   logic [CW-1:0] wait_q;

   logic          resp_valid_q, resp_err_q;
   logic [31:0]   resp_data_q;
   logic [31:0]   mem_addr_q, mem_wdata_q;
   logic [3:0]    mem_mask_q;
   logic          mem_enable_q, mem_cmd_q;

   lsu_size_e     al_size;
   logic [1:0]    al_off;
   logic          al_unsigned;
   logic [3:0]    al_mask;
   logic [31:0]   al_wdata, al_ext;
   logic          al_misaligned;

   // In IDLE the aligner sees the incoming request; afterwards it works from the latched copy
   assign al_size     = (state_q == ST_IDLE) ? lsu_size_e'(req_size_i) : size_q;
   assign al_off      = (state_q == ST_IDLE) ? req_addr_i[1:0]         : off_q;
   assign al_unsigned = (state_q == ST_IDLE) ? req_unsigned_i          : unsigned_q;

   mem_lsu_lane_align u_align (
      .size_i       (al_size),
      .off_i        (al_off),
      .unsigned_i   (al_unsigned),
      .wdata_i      (req_wdata_i),
      .load_data_i  (mem_load_data_i),
      .mask_o       (al_mask),
      .lane_wdata_o (al_wdata),
      .ext_load_o   (al_ext),
      .misaligned_o (al_misaligned)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         cmd_q        <= MEM_CMD_READ;
         size_q       <= LSU_SIZE_B;
         unsigned_q   <= 1'b0;
         off_q        <= 2'b00;
         wait_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= 32'h0;
         mem_addr_q   <= 32'h0;
         mem_mask_q   <= 4'h0;
         mem_wdata_q  <= 32'h0;
         mem_enable_q <= 1'b0;
         mem_cmd_q    <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  cmd_q      <= req_cmd_i;
                  size_q     <= lsu_size_e'(req_size_i);
                  unsigned_q <= req_unsigned_i;
                  off_q      <= req_addr_i[1:0];
                  if (al_misaligned) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_data_q  <= 32'h0;
                  end else begin
                     state_q      <= ST_ACCESS;
                     wait_q       <= TC_LOAD;
                     mem_enable_q <= 1'b1;
                     mem_cmd_q    <= req_cmd_i;
                     mem_addr_q   <= word_addr(req_addr_i);
                     mem_mask_q   <= al_mask;
                     mem_wdata_q  <= (req_cmd_i == MEM_CMD_WRITE) ? al_wdata : 32'h0;
                  end
               end
            end
            ST_ACCESS: begin
               if ((cmd_q == MEM_CMD_WRITE) || mem_valid_i || (wait_q == '0)) begin
                  state_q      <= ST_RESP;
                  resp_valid_q <= 1'b1;
                  // valid on the final wait cycle still counts as a good read
                  resp_err_q   <= (cmd_q == MEM_CMD_READ) && !mem_valid_i;
                  resp_data_q  <= ((cmd_q == MEM_CMD_READ) && mem_valid_i) ? al_ext : 32'h0;
                  mem_enable_q <= 1'b0;
                  mem_cmd_q    <= 1'b0;
                  mem_addr_q   <= 32'h0;
                  mem_mask_q   <= 4'h0;
                  mem_wdata_q  <= 32'h0;
               end else begin
                  wait_q <= wait_q - CW'(1);
               end
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o      = (state_q == ST_IDLE);
   assign resp_valid_o     = resp_valid_q;
   assign resp_data_o      = resp_data_q;
   assign resp_err_o       = resp_err_q;
   assign mem_addr_o       = mem_addr_q;
   assign mem_mask_o       = mem_mask_q;
   assign mem_enable_o     = mem_enable_q;
   assign mem_cmd_o        = mem_cmd_q;
   assign mem_write_data_o = mem_wdata_q;

endmodule
